// File: rtl/any1_pkg.sv
// Shared types and constants for the ANY1 bitfield unit and its two-requester arbiter.
package any1_pkg;

    localparam int VALUE_W = 64;
    localparam int BF_LAT  = 2;

    typedef logic [VALUE_W-1:0] Value;
    typedef logic [5:0]         BfTag;

    typedef enum logic [2:0] {
        BF_SET  = 3'd0,
        BF_CLR  = 3'd1,
        BF_CHG  = 3'd2,
        BF_INS  = 3'd3,
        BF_EXT  = 3'd4,
        BF_EXTU = 3'd5
    } BfFunc;

    // c is the field's low bit position; d is the field width minus one.
    typedef struct packed {
        BfFunc      inst;
        Value       a;
        Value       b;
        logic [5:0] c;
        logic [5:0] d;
        BfTag       tag;
    } BfReq;

endpackage

// File: rtl/any1_bitfield.sv
// Combinational bitfield unit: set/clear/toggle/insert/extract on the field a[c +: d+1].
module any1_bitfield
    import any1_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  BfFunc             func,
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic [5:0]        c,
    input  logic [5:0]        d,
    output logic [DWIDTH-1:0] res,
    output logic [DWIDTH-1:0] mask
);

    logic [6:0]        wid;
    logic [DWIDTH-1:0] lo;
    logic [DWIDTH-1:0] fld;

    always_comb begin
        wid  = {1'b0, d} + 7'd1;
        // A full-width field shifts the ones out entirely, leaving an all-ones mask.
        lo   = ~({DWIDTH{1'b1}} << wid);
        mask = lo << c;
        fld  = (a >> c) & lo;
        res  = a;
        case (func)
            BF_SET:  res = a | mask;
            BF_CLR:  res = a & ~mask;
            BF_CHG:  res = a ^ mask;
            BF_INS:  res = (a & ~mask) | ((b << c) & mask);
            BF_EXT:  res = fld[d] ? (fld | ~lo) : fld;
            BF_EXTU: res = fld;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/any1_bitfield_arb.sv
// Two-requester round-robin front end feeding a shared bitfield unit through a two-stage pipeline.
module any1_bitfield_arb
    import any1_pkg::*;
#(
    parameter int DWIDTH = 64
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [1:0]        req_i,
    output logic [1:0]        ready_o,
    input  BfReq              req0_i,
    input  BfReq              req1_i,
    input  logic              flush_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DWIDTH-1:0] out_res_o,
    output logic [DWIDTH-1:0] out_mask_o,
    output BfTag              out_tag_o,
    output logic              out_src_o,
    output logic              busy_o
);

    logic              s1_valid;
    BfReq              s1_req;
    logic              s1_src;
    logic              s2_valid;
    logic [DWIDTH-1:0] s2_res;
    logic [DWIDTH-1:0] s2_mask;
    BfTag              s2_tag;
    logic              s2_src;
    logic              last_grant;

    logic              s2_load;
    logic              s1_free;
    logic              grant;
    logic              xfer;
    logic [1:0]        ready;
    logic [DWIDTH-1:0] bf_res;
    logic [DWIDTH-1:0] bf_mask;

    // Handshake is built from valids, requests and last_grant only, never from payload.
    always_comb begin
        s2_load = s1_valid && (!s2_valid || out_ready_i) && !flush_i;
        s1_free = !s1_valid || s2_load;
        grant   = (req_i == 2'b11) ? ~last_grant : req_i[1];
        ready   = 2'b00;
        if (rst_ni && !flush_i && s1_free && (req_i != 2'b00))
            ready[grant] = 1'b1;
        xfer    = |(req_i & ready);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid   <= 1'b0;
            s1_req     <= '0;
            s1_src     <= 1'b0;
            last_grant <= 1'b1;
        end else begin
            if (flush_i)
                s1_valid <= 1'b0;
            else if (xfer)
                s1_valid <= 1'b1;
            else if (s2_load)
                s1_valid <= 1'b0;
            if (xfer) begin
                s1_req     <= grant ? req1_i : req0_i;
                s1_src     <= grant;
                last_grant <= grant;
            end
        end
    end

    any1_bitfield #(
        .DWIDTH (DWIDTH)
    ) u_bitfield (
        .func (s1_req.inst),
        .a    (s1_req.a),
        .b    (s1_req.b),
        .c    (s1_req.c),
        .d    (s1_req.d),
        .res  (bf_res),
        .mask (bf_mask)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid <= 1'b0;
            s2_res   <= '0;
            s2_mask  <= '0;
            s2_tag   <= '0;
            s2_src   <= 1'b0;
        end else begin
            if (flush_i)
                s2_valid <= 1'b0;
            else if (s2_load)
                s2_valid <= 1'b1;
            else if (out_ready_i)
                s2_valid <= 1'b0;
            if (s2_load) begin
                s2_res  <= bf_res;
                s2_mask <= bf_mask;
                s2_tag  <= s1_req.tag;
                s2_src  <= s1_src;
            end
        end
    end

    assign ready_o     = ready;
    assign out_valid_o = s2_valid;
    assign out_res_o   = s2_res;
    assign out_mask_o  = s2_mask;
    assign out_tag_o   = s2_tag;
    assign out_src_o   = s2_src;
    assign busy_o      = s1_valid | s2_valid;

endmodule

// File: tb/tb_any1_bitfield_arb.sv
// Directed bench for any1_bitfield_arb: hand-computed results, arbitration order, back-pressure, flush, reset.
module tb_any1_bitfield_arb;
    import any1_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req;
    logic [1:0]  ready;
    BfReq        req0;
    BfReq        req1;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_res;
    logic [63:0] out_mask;
    BfTag        out_tag;
    logic        out_src;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    any1_bitfield_arb #(.DWIDTH(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_i       (req),
        .ready_o     (ready),
        .req0_i      (req0),
        .req1_i      (req1),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_res_o   (out_res),
        .out_mask_o  (out_mask),
        .out_tag_o   (out_tag),
        .out_src_o   (out_src),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic BfReq mk(input BfFunc f, input logic [63:0] a, input logic [63:0] b,
                                input logic [5:0] c, input logic [5:0] d, input BfTag t);
        BfReq r;
        r.inst = f;
        r.a    = a;
        r.b    = b;
        r.c    = c;
        r.d    = d;
        r.tag  = t;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Single uncontended operation; result expected BF_LAT cycles after the transfer cycle.
    task automatic run_one(input string name, input logic src, input BfReq p,
                           input logic [63:0] er, input logic [63:0] em, input BfTag et);
        if (src) req1 = p; else req0 = p;
        req = src ? 2'b10 : 2'b01;
        @(negedge clk);
        chk({name, "_ready"}, ready, src ? 64'd2 : 64'd1);
        step();
        req = 2'b00;
        @(negedge clk);
        chk({name, "_early"}, out_valid, 64'd0);
        for (int i = 1; i < BF_LAT; i++) step();
        @(negedge clk);
        chk({name, "_valid"}, out_valid, 64'd1);
        chk({name, "_res"},   out_res,   er);
        chk({name, "_mask"},  out_mask,  em);
        chk({name, "_tag"},   out_tag,   {58'd0, et});
        chk({name, "_src"},   out_src,   {63'd0, src});
        step();
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(negedge clk);
        step();
        rst_n = 1'b1;
    endtask

    logic [1:0] exp_bp [6] = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    int n_acc;
    int n_rcv;

    initial begin
        rst_n     = 1'b0;
        req       = 2'b11;
        req0      = '0;
        req1      = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        @(negedge clk);
        chk("rst_valid", out_valid, 64'd0);
        chk("rst_busy",  busy,      64'd0);
        chk("rst_ready", ready,     64'd0);
        chk("rst_res",   out_res,   64'd0);
        chk("rst_mask",  out_mask,  64'd0);
        chk("rst_tag",   out_tag,   64'd0);
        chk("rst_src",   out_src,   64'd0);
        step();
        rst_n = 1'b1;
        req   = 2'b00;
        step();

        run_one("bfset", 1'b0, mk(BF_SET, 64'h0, 64'h0, 6'd4, 6'd3, 6'd5),
                64'hF0, 64'hF0, 6'd5);
        @(negedge clk);
        chk("idle_busy", busy, 64'd0);
        step();
        run_one("bfextu", 1'b1, mk(BF_EXTU, 64'h12345678, 64'h0, 6'd8, 6'd7, 6'd9),
                64'h56, 64'hFF00, 6'd9);
        run_one("bfext", 1'b0, mk(BF_EXT, 64'h80, 64'h0, 6'd4, 6'd3, 6'd1),
                64'hFFFF_FFFF_FFFF_FFF8, 64'hF0, 6'd1);
        run_one("bfclr_full", 1'b1, mk(BF_CLR, '1, 64'h0, 6'd0, 6'd63, 6'd63),
                64'h0, '1, 6'd63);
        run_one("bfchg", 1'b0, mk(BF_CHG, 64'hFF, 64'h0, 6'd4, 6'd7, 6'd2),
                64'hF0F, 64'hFF0, 6'd2);

        // Both requesting continuously after reset: requester 0 wins first, then strict alternation.
        pulse_reset();
        req0 = mk(BF_SET, 64'h0, 64'h0, 6'd0, 6'd0, 6'd10);
        req1 = mk(BF_SET, 64'h0, 64'h0, 6'd1, 6'd0, 6'd11);
        for (int i = 0; i < 7; i++) begin
            req = (i < 4) ? 2'b11 : 2'b00;
            @(negedge clk);
            if (i < 4) chk($sformatf("rr_ready%0d", i), ready, (i % 2 == 0) ? 64'd1 : 64'd2);
            if (i >= 2 && i < 6) begin
                chk($sformatf("rr_valid%0d", i), out_valid, 64'd1);
                chk($sformatf("rr_src%0d", i),   out_src,   ((i - 2) % 2 == 0) ? 64'd0 : 64'd1);
                chk($sformatf("rr_res%0d", i),   out_res,   ((i - 2) % 2 == 0) ? 64'd1 : 64'd2);
            end
            if (i == 6) chk("rr_drain", out_valid, 64'd0);
            step();
        end

        // Back-pressure: consumer stalls for 4 cycles while requester 0 streams 4 ops.
        n_acc = 0;
        n_rcv = 0;
        for (int i = 0; i < 10; i++) begin
            out_ready = (i >= 4);
            req       = (n_acc < 4) ? 2'b01 : 2'b00;
            req0      = mk(BF_SET, 64'h0, 64'h0, n_acc[5:0], 6'd0, n_acc[5:0]);
            @(negedge clk);
            if (i < 6) chk($sformatf("bp_ready%0d", i), ready, {62'd0, exp_bp[i]});
            if (i == 2 || i == 3) begin
                chk($sformatf("bp_hold_valid%0d", i), out_valid, 64'd1);
                chk($sformatf("bp_hold_res%0d", i),   out_res,   64'd1);
            end
            if (ready[0] && req[0]) n_acc++;
            if (out_valid && out_ready) begin
                chk($sformatf("bp_out%0d", n_rcv), out_res, 64'd1 << n_rcv);
                n_rcv++;
            end
            step();
        end
        chk("bp_accepted", n_acc, 64'd4);
        chk("bp_received", n_rcv, 64'd4);

        // Flush with both stages full and a competing request.
        out_ready = 1'b0;
        req0      = mk(BF_SET, 64'h0, 64'h0, 6'd2, 6'd0, 6'd3);
        req       = 2'b01;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk($sformatf("fl_fill%0d", i), ready, 64'd1);
            step();
        end
        flush     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("fl_ready",     ready,     64'd0);
        chk("fl_full_busy", busy,      64'd1);
        step();
        flush = 1'b0;
        req   = 2'b00;
        @(negedge clk);
        chk("fl_valid", out_valid, 64'd0);
        chk("fl_busy",  busy,      64'd0);
        step();
        @(negedge clk);
        chk("fl_busy_after", busy, 64'd0);
        step();

        // Reset the cycle after accepting an insert; nothing may emerge until a retry.
        req0 = mk(BF_INS, 64'h0, 64'hAB, 6'd16, 6'd7, 6'd7);
        req  = 2'b01;
        @(negedge clk);
        chk("rs_accept", ready, 64'd1);
        step();
        rst_n = 1'b0;
        req   = 2'b11;
        @(negedge clk);
        chk("rs_valid", out_valid, 64'd0);
        chk("rs_busy",  busy,      64'd0);
        chk("rs_ready", ready,     64'd0);
        step();
        rst_n = 1'b1;
        req   = 2'b00;
        for (int i = 0; i < BF_LAT + 1; i++) begin
            @(negedge clk);
            chk($sformatf("rs_quiet%0d", i), out_valid, 64'd0);
            step();
        end
        run_one("bfins", 1'b0, mk(BF_INS, 64'h0, 64'hAB, 6'd16, 6'd7, 6'd7),
                64'h00AB_0000, 64'h00FF_0000, 6'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/any1_bitfield_arb.md
ANY1_BITFIELD_ARB -- requirements
Module: any1_bitfield_arb

Interface
REQ-001 Parameter DWIDTH, 64, datapath width; SHALL match the width of the Value type.
REQ-002 clk_i  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_ni  in  1  reset, asynchronous and active-low.
REQ-004 req_i  in  2  per-requester request valid (index 0 = ALU0, 1 = ALU1).
REQ-005 ready_o  out  2  per-requester accept; a transfer occurs when req_i[k] and ready_o[k] are both high.
REQ-006 req0_i, req1_i  in  BfReq  per-requester payload (inst, a, b, c, d, tag).
REQ-007 flush_i  in  1  kills all in-flight operations.
REQ-008 out_valid_o  out  1  result valid.
REQ-009 out_ready_i  in  1  consumer accept.
REQ-010 out_res_o  out  DWIDTH  bitfield result.
REQ-011 out_mask_o  out  DWIDTH  generated mask.
REQ-012 out_tag_o  out  BfTag  tag of the result.
REQ-013 out_src_o  out  1  originating requester index.
REQ-014 busy_o  out  1  high when either pipeline stage is valid.

Function
REQ-015 Pipeline SHALL have stage S1 (registered request plus source index) and stage S2 (registered result, mask, tag and source); S2 drives the out_* ports.
REQ-016 S1 SHALL feed a single shared any1_bitfield instance combinationally, and the result SHALL be captured into S2.
REQ-017 Latency SHALL be 2 cycles from acceptance to out_valid_o when there is no back-pressure.
REQ-018 S2 SHALL load when S1 is valid and (S2 is empty or out_ready_i is high).
REQ-019 S2 SHALL clear when out_ready_i is high and S1 does not load into it.
REQ-020 S1 SHALL accept a new request when S1 is empty or S1 is advancing into S2.
REQ-021 At most one ready_o bit SHALL be high per cycle, and it SHALL be the granted requester only.
REQ-022 Arbitration SHALL be round-robin.
REQ-023 When both requesters request, the one not equal to last_grant SHALL be granted.
REQ-024 When one requester requests, it SHALL be granted.
REQ-025 last_grant SHALL update only on an actual transfer.
REQ-026 ready_o SHALL depend only on req_i, last_grant, the stage valids, out_ready_i and flush_i (no combinational path from payload).
REQ-027 Full pipeline with out_ready_i low: ready_o SHALL be 0 and S1/S2 SHALL hold unchanged.
REQ-028 Simultaneous retire and accept: full throughput of one operation per cycle SHALL be sustained.
REQ-029 flush_i SHALL clear the S1 and S2 valids at the next edge.
REQ-030 ready_o SHALL be 0 in any cycle flush_i is high; flush takes priority over accept and retire.
REQ-031 Payload registers SHALL load only on transfer and hold otherwise; their contents are don't-care when the stage is invalid.

Reset
REQ-032 On rst_ni low, the S1 and S2 valids SHALL clear immediately.
REQ-033 On rst_ni low, out_valid_o, busy_o and ready_o SHALL be 0.
REQ-034 On rst_ni low, out_res_o, out_mask_o, out_tag_o and out_src_o SHALL reset to 0.
REQ-035 last_grant SHALL reset to 1, so requester 0 wins the first tie.
REQ-036 Reset asserted mid-operation SHALL discard all in-flight operations, with no output after reset release until a new accept.

Structure
REQ-037 BfReq struct, BfTag typedef (6 bits) and BF_LAT=2 constant SHALL reside in any1_pkg.
REQ-038 The only sub-module SHALL be any1_bitfield, instantiated once with DWIDTH passed through.

Verification
REQ-039 Bench SHALL cover: req0 BFSET (func=0), a=0, c=4, d=3, tag=5 -> 2 cycles later out_res_o=0xF0, out_tag_o=5, out_src_o=0.
REQ-040 Bench SHALL cover: req1 BFEXTU (func=5), a=0x12345678, b=0, c=8, d=7 -> out_res_o=0x56, out_src_o=1.
REQ-041 Bench SHALL cover: both requesting continuously after reset -> grants alternate 0,1,0,1; out_src_o sequence matches; one result per cycle.
REQ-042 Bench SHALL cover: out_ready_i low for 4 cycles with a stream in flight -> ready_o=0 after 2 accepts; out_res_o stable; no loss or duplication on release.
REQ-043 Bench SHALL cover: flush_i with S1 and S2 full plus a simultaneous req0 -> next cycle out_valid_o=0, busy_o=0, request not accepted.
REQ-044 Bench SHALL cover: BFINS (func=3), a=0, b=0xAB, c=16, d=7, with rst_ni pulsed low the cycle after accept -> no output; retry after reset gives 0x00AB0000.
